// File: rtl/carry_propagate_stage.sv
// Carry-propagate stage behind a carry-save tree. It aligns the valid and tag with the
// tree latency, then resolves the two rows in a skewed, slice-wise ripple pipeline.
module carry_propagate_stage #(
  parameter int TREE_LAT = 8,
  parameter int SLICE    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_tag,
  input  logic [1:0][63:0] tree_in,
  output logic             out_valid,
  output logic [4:0]       out_tag,
  output logic [63:0]      sum,
  output logic             carry_out
);

  localparam int NSTG = 64 / SLICE;
  localparam int PD   = (NSTG > 1) ? NSTG - 1 : 1;

  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  endfunction

  logic [TREE_LAT-1:0] dly_vld;
  logic [4:0]          dly_tag [TREE_LAT];

  // Stage inputs (s_*), stage results (n_*, sr) and inter-stage registers (*_p)
  logic        s_vld [NSTG];
  logic [4:0]  s_tag [NSTG];
  logic [63:0] s_a   [NSTG];
  logic [63:0] s_b   [NSTG];
  logic [63:0] s_acc [NSTG];
  logic        s_c   [NSTG];
  logic [SLICE:0] sr [NSTG];
  logic [63:0] n_acc [NSTG];
  logic        n_c   [NSTG];

  logic        vld_p [PD];
  logic [4:0]  tag_p [PD];
  logic [63:0] a_p   [PD];
  logic [63:0] b_p   [PD];
  logic [63:0] acc_p [PD];
  logic        c_p   [PD];

  // Valid/tag delay line matching the upstream tree latency
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_vld <= '0;
      for (int i = 0; i < TREE_LAT; i++) dly_tag[i] <= '0;
    end else begin
      dly_vld[0] <= in_valid;
      dly_tag[0] <= in_tag;
      for (int i = 1; i < TREE_LAT; i++) begin
        dly_vld[i] <= dly_vld[i-1];
        dly_tag[i] <= dly_tag[i-1];
      end
    end
  end

  always_comb begin
    s_vld[0] = dly_vld[TREE_LAT-1];
    s_tag[0] = dly_tag[TREE_LAT-1];
    s_a[0]   = tree_in[0];
    s_b[0]   = tree_in[1];
    s_acc[0] = '0;
    s_c[0]   = 1'b0;
    for (int k = 1; k < NSTG; k++) begin
      s_vld[k] = vld_p[k-1];
      s_tag[k] = tag_p[k-1];
      s_a[k]   = a_p[k-1];
      s_b[k]   = b_p[k-1];
      s_acc[k] = acc_p[k-1];
      s_c[k]   = c_p[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      sr[k]    = slice_add(s_a[k][k*SLICE +: SLICE], s_b[k][k*SLICE +: SLICE], s_c[k]);
      n_acc[k] = s_acc[k];
      n_acc[k][k*SLICE +: SLICE] = sr[k][SLICE-1:0];
      n_c[k]   = sr[k][SLICE];
    end
  end

  // Stage boundary k -> k+1: control under reset, data free-running
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTG - 1; k++) begin
      if (rst) vld_p[k] <= 1'b0;
      else     vld_p[k] <= s_vld[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTG - 1; k++) begin
      tag_p[k] <= s_tag[k];
      a_p[k]   <= s_a[k];
      b_p[k]   <= s_b[k];
      acc_p[k] <= n_acc[k];
      c_p[k]   <= n_c[k];
    end
  end

  // Final stage loads the result registers, holding them between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      out_valid <= s_vld[NSTG-1];
      if (s_vld[NSTG-1]) begin
        out_tag   <= s_tag[NSTG-1];
        sum       <= n_acc[NSTG-1];
        carry_out <= n_c[NSTG-1];
      end
    end
  end

endmodule
